deserializer_stream: RTL
========================

// Module: deserializer_stream
// PURPOSE
//  Parametrised serial-to-parallel converter with output handshake; successor to the basic
//  shift-in deserializer. Gated by iEn/iLoading, it assembles DATA_SIZE-bit words MSB- or
//  LSB-first and commits each to a one-word holding register drained by valid/ready.
//  Flags overrun, and aborts a frame when iLoading drops mid-word.
//  Sits between the serial front end and the parallel datapath/consumer.
// PARAMETERS
//  DATA_SIZE  8  word width in bits, >= 2
//  MSB_FIRST  1  1: first received bit lands in oData[DATA_SIZE-1]; 0: in oData[0]
//  CNT_W      localparam $clog2(DATA_SIZE+1), width of oBit_count
// PORTS
//  iClk         in   1          clock; all state on rising edge
//  iRst         in   1          asynchronous, active-high reset
//  iEn          in   1          clock enable; 0 freezes the receive side only (cnt/shift/state)
//  iData_in     in   1          serial data bit, sampled when iEn & iLoading
//  iLoading     in   1          frame-active; 1 = bit present this cycle
//  iReady       in   1          consumer accepts oData when oValid & iReady
//  iClr         in   1          synchronous clear of sticky flags oOverrun/oAbort
//  oData        out  DATA_SIZE  holding register, stable while oValid=1
//  oValid       out  1          holding register full
//  oBusy        out  1          1 while a word is partially received (state != IDLE)
//  oBit_count   out  CNT_W      bits received in current word, 0..DATA_SIZE-1
//  oOverrun     out  1          sticky: completed word dropped because holding reg full
//  oAbort       out  1          sticky: iLoading fell (iEn=1) with partial word pending
//  oParity_err  out  1          only with DESER_PARITY_EN: parity result of held word
// BEHAVIOUR
//  Reset (iRst=1, async): state=IDLE, shift reg=0, cnt=0, oData=0, oValid=0, oOverrun=0,
//   oAbort=0, oParity_err=0. Reset mid-word discards the partial word; no flag set.
//  "Bit accepted" = iEn & iLoading at a rising edge.
//  FSM: IDLE -> SHIFT on first accepted bit (cnt->1). SHIFT: each accepted bit shifts in,
//   cnt+1. On the DATA_SIZE-th accepted bit: COMMIT (below), cnt->0, state->IDLE
//   (or ->PARITY when the optional feature is compiled in).
//  MSB_FIRST=1: sr <= {sr[DATA_SIZE-2:0], bit}; MSB_FIRST=0: sr <= {bit, sr[DATA_SIZE-1:1]}.
//  COMMIT: drain = oValid & iReady. If !oValid or drain: oData <= completed word, oValid <= 1
//   (same edge). Else: word dropped, oData unchanged, oOverrun <= 1.
//  Latency: oValid rises on the same edge that samples the last bit (visible next cycle).
//  Drain without commit: oValid & iReady -> oValid <= 0. Back-to-back words: commit+drain on
//   the same edge keeps oValid=1 with new data; no bubble, no overrun.
//  Abort: iEn=1, iLoading=0, state != IDLE -> partial word discarded, cnt->0, IDLE, oAbort<=1.
//   iEn=0 never aborts; receive state holds, output handshake keeps running.
//  iClr clears oOverrun/oAbort; a set event on the same edge wins (flag stays 1).
//  oBusy = (state != IDLE); oBit_count = cnt. No combinational input->output paths.
// CONFIGURATION
//  DESER_PARITY_EN defined: after DATA_SIZE data bits FSM enters PARITY; next accepted bit is
//   an even-parity bit; COMMIT occurs on that edge, oParity_err <= ^{word,parity_bit},
//   loaded with oData. Abort rule also applies in PARITY. oParity_err is don't-care when oValid=0.
//  Undefined: no PARITY state, no oParity_err port; COMMIT on the last data bit.
// TESTING  (DATA_SIZE=8)
//  1 MSB_FIRST=1, bits 1,0,1,0,0,1,0,1, iReady=1 -> oData=8'hA5, oValid=1 one cycle, then 0.
//  2 MSB_FIRST=0, same bit order -> oData=8'hA5 (0xA5 bit 0 first).
//  3 iReady=0, send 8'h3C then 8'hC3 -> oData stays 8'h3C, oOverrun=1; iClr -> oOverrun=0.
//  4 Two words back-to-back, iReady=1 from the 8th bit on -> oValid stays 1, 8'h11 then 8'h22.
//  5 3 bits, then iLoading=0 (iEn=1) -> oAbort=1, oBit_count=0, oBusy=0; next 8 bits 8'h5A OK.
//  6 iRst pulse after 5 bits, async mid-cycle -> all outputs 0 immediately; 8'hFF then OK.
//  7 iEn=0 for 4 cycles mid-word, iLoading held -> oBit_count frozen; word completes correctly.
//  8 DESER_PARITY_EN: 8'hA5 + parity 0 -> oParity_err=0; 8'hA5 + parity 1 -> oParity_err=1.

Source files
------------

// File: rtl/deserializer_stream.sv
// deserializer_stream: gated serial-to-parallel converter feeding a one-word valid/ready holding register.
// Optional feature: define DESER_PARITY_EN to take a trailing even-parity bit per word and drive oParity_err.
module deserializer_stream #(
   parameter int DATA_SIZE = 8,
   parameter bit MSB_FIRST = 1'b1,
   localparam int CNT_W = $clog2(DATA_SIZE + 1)
) (
   input  logic                 iClk,
   input  logic                 iRst,
   input  logic                 iEn,
   input  logic                 iData_in,
   input  logic                 iLoading,
   input  logic                 iReady,
   input  logic                 iClr,
   output logic [DATA_SIZE-1:0] oData,
   output logic                 oValid,
   output logic                 oBusy,
   output logic [CNT_W-1:0]     oBit_count,
   output logic                 oOverrun,
`ifdef DESER_PARITY_EN
   output logic                 oAbort,
   output logic                 oParity_err
`else
   output logic                 oAbort
`endif
);

   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

   state_t               state;
   logic [DATA_SIZE-1:0] shiftReg;
   logic [CNT_W-1:0]     cnt;
   logic [DATA_SIZE-1:0] shifted;
   logic [DATA_SIZE-1:0] commitWord;
   logic                 accept;
   logic                 abort;
   logic                 drain;
   logic                 lastBit;
   logic                 commit;
   logic                 store;
   logic                 overrunSet;

   assign accept  = iEn & iLoading;
   assign abort   = iEn & ~iLoading & (state != IDLE);
   assign drain   = oValid & iReady;
   assign lastBit = (state == SHIFT) && (cnt == CNT_W'(DATA_SIZE - 1));
   assign shifted = MSB_FIRST ? {shiftReg[DATA_SIZE-2:0], iData_in}
                              : {iData_in, shiftReg[DATA_SIZE-1:1]};

`ifdef DESER_PARITY_EN
   // The full word already sits in shiftReg; the edge that commits samples only the parity bit.
   assign commit     = accept & (state == PARITY);
   assign commitWord = shiftReg;
`else
   assign commit     = accept & lastBit;
   assign commitWord = shifted;
`endif

   // A completed word is stored when the holding register is empty or is being drained this edge.
   assign store      = commit & (~oValid | drain);
   assign overrunSet = commit & ~(~oValid | drain);

   assign oBusy      = (state != IDLE);
   assign oBit_count = cnt;

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state    <= IDLE;
         shiftReg <= '0;
         cnt      <= '0;
         oData    <= '0;
         oValid   <= 1'b0;
         oOverrun <= 1'b0;
         oAbort   <= 1'b0;
`ifdef DESER_PARITY_EN
         oParity_err <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values, so the
         // commit and the drain decisions below see the same oValid regardless of statement order.
         if (store) begin
            oData  <= commitWord;
            oValid <= 1'b1;
`ifdef DESER_PARITY_EN
            oParity_err <= ^{shiftReg, iData_in};
`endif
         end else if (drain) begin
            oValid <= 1'b0;
         end

         // Sticky flags: a set event on the same edge as iClr wins.
         oOverrun <= overrunSet | (oOverrun & ~iClr);
         oAbort   <= abort | (oAbort & ~iClr);

         if (abort) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (accept) begin
            case (state)
               IDLE: begin
                  shiftReg <= shifted;
                  cnt      <= CNT_W'(1);
                  state    <= SHIFT;
               end
               SHIFT: begin
                  shiftReg <= shifted;
                  if (lastBit) begin
                     cnt <= '0;
`ifdef DESER_PARITY_EN
                     state <= PARITY;
`else
                     state <= IDLE;
`endif
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
